grostl_control_serial: RTL and testbench
========================================

GROSTL_CONTROL_SERIAL -- requirements
Module: grostl_control_serial

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of permutation rounds per block (legal 1..16).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to compress the block presented on m_in; sampled only in IDLE.
REQ-005 first  input  1  sampled with start; 1 = load IV into chaining register, 0 = keep chaining value.
REQ-006 busy  output  1  high from LOAD through FIN inclusive.
REQ-007 done  output  1  one-cycle pulse; datapath dout and chaining register valid.
REQ-008 wr_m  output  1  message-register write enable to datapath.
REQ-009 wr_h  output  1  chaining-register write enable to datapath.
REQ-010 sel_m  output  2  00 m_in, 01 round output, 10 m xor h.
REQ-011 sel_h  output  1  0 h_in (IV), 1 m xor h.
REQ-012 sel_pq  output  1  permutation select; held 0 (P) in every state.
REQ-013 round  output  4  current round index.

Function
REQ-014 States: IDLE, LOAD, XOR, RND0, RND1, FIN, DONE; all outputs SHALL be Moore decodes of registered state, round counter and first flag.
REQ-015 IDLE: all strobes 0, round=0; start=1 -> LOAD, first latched into a flag register; start=0 -> stay.
REQ-016 LOAD (1 cycle): wr_m=1, sel_m=00; if latched first=1 also wr_h=1, sel_h=0; -> XOR.
REQ-017 XOR (1 cycle): wr_m=1, sel_m=10, wr_h=0; round counter cleared to 0; -> RND0.
REQ-018 RND0 (pipeline fill, 1 cycle): wr_m=0, wr_h=0, round=counter; -> RND1.
REQ-019 RND1 (1 cycle): wr_m=1, sel_m=01, round=counter unchanged from RND0; if counter=NUM_ROUNDS-1 -> FIN, else counter+1 and -> RND0.
REQ-020 round SHALL stay stable across each RND0/RND1 pair; counter 4 bits, never wraps past NUM_ROUNDS-1.
REQ-021 FIN (1 cycle): wr_h=1, sel_h=1, wr_m=0; -> DONE.
REQ-022 DONE (1 cycle): done=1, busy=0, strobes 0; -> IDLE unconditionally.
REQ-023 Latency: start sampled at edge N -> LOAD in cycle N+1, done high in cycle N+3+2*NUM_ROUNDS+1 (N+24 for default); busy high exactly 3+2*NUM_ROUNDS cycles.
REQ-024 start while not IDLE (including DONE) SHALL be ignored, not queued; first ignored unless start accepted.
REQ-025 Back-to-back: start held high SHALL restart from IDLE, giving one idle cycle between done and next LOAD.
REQ-026 wr_m and wr_h SHALL never both be 1 except in LOAD with first=1.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, first flag 0, all outputs 0 (round=0, sel_* =0), independent of clk.
REQ-028 Reset mid-operation SHALL abort the block with no done pulse; first edge after release behaves as IDLE.

Structure
REQ-029 State enum, NUM_ROUNDS default and sel_m encodings SHALL live in shared package grostl_pkg, also used by the datapath.
REQ-030 Single flat FSM plus counter; no sub-module. Top level grostl_serial instantiates this block and grostl_compress_serial.

Verification
REQ-031 Reset then start=1, first=1 one cycle -> LOAD with wr_m=1, wr_h=1, sel_h=0; done exactly 24 cycles after start edge; busy high 23 cycles.
REQ-032 Round trace: log round on every RND1 cycle -> sequence 0,1,...,9, each value also present in preceding RND0; 10 wr_m/sel_m=01 pulses.
REQ-033 Two blocks first=1 then first=0 with datapath and golden model -> second LOAD has wr_h=0; final chaining value matches model.
REQ-034 start pulsed at cycles 5 and 12 during busy -> ignored; exactly one done pulse.
REQ-035 rst_n low in RND1 with round=4 -> outputs 0 asynchronously, no done; new start after release completes normally in 24 cycles.
REQ-036 NUM_ROUNDS=14 build -> busy 31 cycles, last round value 13, counter never exceeds 13.

Source files
------------

// File: rtl/grostl_pkg.sv
// Shared Groestl serial-core definitions: controller states, round count, mux encodings.
// Imported by both the control FSM and the compression datapath.
package grostl_pkg;

  localparam int GROSTL_NUM_ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XOR,
    ST_RND0,
    ST_RND1,
    ST_FIN,
    ST_DONE
  } state_e;

  // Message-register input mux
  localparam logic [1:0] SEL_M_IN  = 2'b00;
  localparam logic [1:0] SEL_M_RND = 2'b01;
  localparam logic [1:0] SEL_M_XOR = 2'b10;

  // Chaining-register input mux
  localparam logic SEL_H_IV  = 1'b0;
  localparam logic SEL_H_XOR = 1'b1;

endpackage

// File: rtl/grostl_control_serial.sv
// Serial Groestl compression controller: one block = LOAD, XOR, NUM_ROUNDS x (RND0,RND1), FIN, DONE.
// All outputs are Moore decodes of state, round counter and latched first flag; start ignored outside IDLE.
module grostl_control_serial
  import grostl_pkg::*;
#(
  parameter int NUM_ROUNDS = GROSTL_NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       first,
  output logic       busy,
  output logic       done,
  output logic       wr_m,
  output logic       wr_h,
  output logic [1:0] sel_m,
  output logic       sel_h,
  output logic       sel_pq,
  output logic [3:0] round
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       first_q, first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          first_d = first;
        end
      end
      ST_LOAD: state_d = ST_XOR;
      ST_XOR: begin
        cnt_d   = 4'd0;
        state_d = ST_RND0;
      end
      ST_RND0: state_d = ST_RND1;
      // Counter advances only on the second half of a round so round stays stable across the pair
      ST_RND1: begin
        if (cnt_q == LAST_RND) begin
          state_d = ST_FIN;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_RND0;
        end
      end
      ST_FIN:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    wr_m   = 1'b0;
    wr_h   = 1'b0;
    sel_m  = SEL_M_IN;
    sel_h  = SEL_H_IV;
    sel_pq = 1'b0;
    round  = 4'd0;
    case (state_q)
      ST_LOAD: begin
        busy = 1'b1;
        wr_m = 1'b1;
        wr_h = first_q;
      end
      ST_XOR: begin
        busy  = 1'b1;
        wr_m  = 1'b1;
        sel_m = SEL_M_XOR;
      end
      ST_RND0: begin
        busy  = 1'b1;
        round = cnt_q;
      end
      ST_RND1: begin
        busy  = 1'b1;
        wr_m  = 1'b1;
        sel_m = SEL_M_RND;
        round = cnt_q;
      end
      ST_FIN: begin
        busy  = 1'b1;
        wr_h  = 1'b1;
        sel_h = SEL_H_XOR;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_grostl_control_serial.sv
// Directed bench for the serial Groestl controller (default 10 rounds, plus a 14-round instance).
module tb_grostl_control_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, first = 1'b0, start14 = 1'b0;
  logic       busy, done, wr_m, wr_h, sel_h, sel_pq;
  logic [1:0] sel_m;
  logic [3:0] round;
  logic       busy14, done14, wr_m14, wr_h14, sel_h14, sel_pq14;
  logic [1:0] sel_m14;
  logic [3:0] round14;

  int tests = 0, fails = 0;
  logic [11:0] vec [0:63];
  int lat, busy_n, r1_n, seq_err, both_err, done_n;

  always #5 clk = ~clk;

  grostl_control_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first(first),
    .busy(busy), .done(done), .wr_m(wr_m), .wr_h(wr_h),
    .sel_m(sel_m), .sel_h(sel_h), .sel_pq(sel_pq), .round(round)
  );

  grostl_control_serial #(.NUM_ROUNDS(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .start(start14), .first(1'b1),
    .busy(busy14), .done(done14), .wr_m(wr_m14), .wr_h(wr_h14),
    .sel_m(sel_m14), .sel_h(sel_h14), .sel_pq(sel_pq14), .round(round14)
  );

  // {busy, done, wr_m, wr_h, sel_m[1:0], sel_h, sel_pq, round[3:0]}
  wire [11:0] out = {busy, done, wr_m, wr_h, sel_m, sel_h, sel_pq, round};

  localparam logic [11:0] V_IDLE    = 12'b0_0_0_0_00_0_0_0000;
  localparam logic [11:0] V_LOAD_F1 = 12'b1_0_1_1_00_0_0_0000;
  localparam logic [11:0] V_LOAD_F0 = 12'b1_0_1_0_00_0_0_0000;
  localparam logic [11:0] V_XOR     = 12'b1_0_1_0_10_0_0_0000;
  localparam logic [11:0] V_RND0_0  = 12'b1_0_0_0_00_0_0_0000;
  localparam logic [11:0] V_RND1_0  = 12'b1_0_1_0_01_0_0_0000;
  localparam logic [11:0] V_RND1_4  = 12'b1_0_1_0_01_0_0_0100;
  localparam logic [11:0] V_RND1_9  = 12'b1_0_1_0_01_0_0_1001;
  localparam logic [11:0] V_FIN     = 12'b1_0_0_1_00_1_0_0000;
  localparam logic [11:0] V_DONE    = 12'b0_1_0_0_00_0_0_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one block, capture outputs per cycle until done (bounded); optional stray starts while busy
  task automatic run_block(input logic f, input bit stray);
    int k;
    start = 1'b1;
    first = f;
    tick();
    start = 1'b0;
    first = 1'b0;
    k = 1;
    vec[1] = out;
    while (!done && k < 60) begin
      start = stray && (k == 5 || k == 12);
      first = start;
      tick();
      k++;
      vec[k] = out;
    end
    start = 1'b0;
    first = 1'b0;
    lat = k;
  endtask

  task automatic analyze();
    busy_n = 0; r1_n = 0; seq_err = 0; both_err = 0; done_n = 0;
    for (int k = 1; k <= lat; k++) begin
      if (vec[k][11]) busy_n++;
      if (vec[k][10]) done_n++;
      if (vec[k][9] && vec[k][8] && k != 1) both_err++;
      if (vec[k][9] && vec[k][7:6] == 2'b01) begin
        if (vec[k][3:0] != 4'(r1_n)) seq_err++;
        if (vec[k-1][11:4] != 8'b1000_0000 || vec[k-1][3:0] != vec[k][3:0]) seq_err++;
        r1_n++;
      end
    end
  endtask

  initial begin
    int b14, max14, k14;

    #2;
    chk("reset_async_outputs", 32'(out), 32'(V_IDLE));
    tick();
    chk("reset_held_outputs", 32'(out), 32'(V_IDLE));
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", 32'(out), 32'(V_IDLE));

    // Block 1: first=1, full trace
    run_block(1'b1, 1'b0);
    analyze();
    chk("load_first1", 32'(vec[1]), 32'(V_LOAD_F1));
    chk("xor_cycle", 32'(vec[2]), 32'(V_XOR));
    chk("rnd0_round0", 32'(vec[3]), 32'(V_RND0_0));
    chk("rnd1_round0", 32'(vec[4]), 32'(V_RND1_0));
    chk("rnd1_round9", 32'(vec[22]), 32'(V_RND1_9));
    chk("fin_cycle", 32'(vec[23]), 32'(V_FIN));
    chk("done_cycle", 32'(vec[24]), 32'(V_DONE));
    chk("latency", 32'(lat), 32'd24);
    chk("busy_cycles", 32'(busy_n), 32'd23);
    chk("rnd1_pulses", 32'(r1_n), 32'd10);
    chk("round_sequence", 32'(seq_err), 32'd0);
    chk("wr_m_wr_h_exclusive", 32'(both_err), 32'd0);
    tick();
    chk("idle_after_done", 32'(out), 32'(V_IDLE));

    // Block 2: first=0 keeps chaining value
    run_block(1'b0, 1'b0);
    analyze();
    chk("load_first0", 32'(vec[1]), 32'(V_LOAD_F0));
    chk("latency_blk2", 32'(lat), 32'd24);
    chk("fin_blk2", 32'(vec[23]), 32'(V_FIN));
    tick();

    // Stray starts during busy are ignored, not queued
    run_block(1'b1, 1'b1);
    analyze();
    chk("stray_latency", 32'(lat), 32'd24);
    chk("stray_done_count", 32'(done_n), 32'd1);
    tick();
    chk("stray_not_queued_1", 32'(out), 32'(V_IDLE));
    tick();
    chk("stray_not_queued_2", 32'(out), 32'(V_IDLE));

    // Back-to-back: start held high through DONE
    start = 1'b1;
    first = 1'b0;
    tick();
    chk("b2b_load", 32'(out), 32'(V_LOAD_F0));
    for (int i = 0; i < 60 && !done; i++) tick();
    chk("b2b_done", 32'(done), 32'd1);
    tick();
    chk("b2b_idle_gap", 32'(out), 32'(V_IDLE));
    tick();
    chk("b2b_restart_load", 32'(out), 32'(V_LOAD_F0));
    start = 1'b0;
    for (int i = 0; i < 60 && !done; i++) tick();
    tick();

    // Reset mid-RND1 at round 4
    start = 1'b1;
    first = 1'b1;
    tick();
    start = 1'b0;
    first = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("rnd1_round4", 32'(out), 32'(V_RND1_4));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_block", 32'(out), 32'(V_IDLE));
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_n++;
    end
    chk("no_done_after_abort", 32'(done_n), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_release", 32'(out), 32'(V_IDLE));
    run_block(1'b1, 1'b0);
    chk("latency_after_reset", 32'(lat), 32'd24);
    tick();

    // 14-round instance
    start14 = 1'b1;
    tick();
    start14 = 1'b0;
    k14 = 1;
    b14 = busy14 ? 1 : 0;
    max14 = 0;
    while (!done14 && k14 < 60) begin
      tick();
      k14++;
      if (busy14) b14++;
      if (busy14 && int'(round14) > max14) max14 = int'(round14);
    end
    chk("nr14_latency", 32'(k14), 32'd32);
    chk("nr14_busy_cycles", 32'(b14), 32'd31);
    chk("nr14_max_round", 32'(max14), 32'd13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
